// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of a downstream 4:1 mux, holding sel for SETTLE_CYC+1 cycles per
// channel, and presents the captured bits as a 4-bit frame with a single-cycle valid pulse.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] mask_q, mask_q_nxt;
  logic [3:0] shadow, shadow_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] frame_nxt;
  logic       frame_valid_nxt;
  logic [3:0] shadow_upd;
  logic [3:0] remaining;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Enabled channels strictly above the current select; scanning never wraps.
  assign remaining = mask_q & (4'b1110 << sel);
  assign busy      = (state != IDLE);

  always_comb begin
    shadow_upd      = shadow;
    shadow_upd[sel] = mux_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      mask_q      <= 4'd0;
      shadow      <= 4'd0;
      sel         <= 2'd0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mask_q      <= mask_q_nxt;
      shadow      <= shadow_nxt;
      sel         <= sel_nxt;
      frame       <= frame_nxt;
      frame_valid <= frame_valid_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    mask_q_nxt      = mask_q;
    shadow_nxt      = shadow;
    sel_nxt         = sel;
    frame_nxt       = frame;
    frame_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (mask != 4'd0) begin
            mask_q_nxt = mask;
            sel_nxt    = lowest_set(mask);
            shadow_nxt = 4'd0;
            cnt_nxt    = 4'd0;
            state_nxt  = SETTLE;
          end else begin
            // Empty scan still reports, so a requester always sees a frame.
            frame_nxt       = 4'd0;
            frame_valid_nxt = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SAMPLE: begin
        shadow_nxt = shadow_upd;
        if (remaining != 4'd0) begin
          sel_nxt   = lowest_set(remaining);
          state_nxt = SETTLE;
        end else begin
          frame_nxt       = shadow_upd & mask_q;
          frame_valid_nxt = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE_CYC=1 and 3) each driving a modelled 4:1 mux.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, which;
  logic [3:0] mask, data_in;
  logic       start1, start3;
  logic [1:0] sel1, sel3;
  logic       busy1, busy3, fv1, fv3;
  logic [3:0] frame1, frame3;
  logic       mux1, mux3;
  logic [1:0] o_sel;
  logic       o_busy, o_fv;
  logic [3:0] o_frame;

  assign start1  = start & ~which;
  assign start3  = start & which;
  assign mux1    = data_in[sel1];
  assign mux3    = data_in[sel3];
  assign o_sel   = which ? sel3 : sel1;
  assign o_busy  = which ? busy3 : busy1;
  assign o_fv    = which ? fv3 : fv1;
  assign o_frame = which ? frame3 : frame1;

  mux_scan_ctrl #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mask(mask), .mux_out(mux1),
    .sel(sel1), .busy(busy1), .frame(frame1), .frame_valid(fv1)
  );

  mux_scan_ctrl #(.SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .mask(mask), .mux_out(mux3),
    .sel(sel3), .busy(busy3), .frame(frame3), .frame_valid(fv3)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] last_sel[2];
  logic [3:0] last_frame[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each enabled channel, ascending, holds sel for s+1 cycles; its bit is whatever
  // data_in carries in the last of those cycles. data_in switches from d_early to d_late
  // at cycle sw (cycle 0 = the cycle after the accept edge).
  task automatic scan(input logic w, input logic [3:0] m, input logic [3:0] d_early,
                      input logic [3:0] d_late, input int sw, input bit disturb, input bit chain);
    int s, n, lat, sk;
    int seq[$];
    logic [3:0] exp_frame;
    logic [1:0] esel;
    which = w;
    s = w ? 3 : 1;
    n = 0;
    exp_frame = 4'd0;
    esel = last_sel[w];
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        sk = (n + 1) * (s + 1) - 1;
        exp_frame[ch] = (sk >= sw) ? d_late[ch] : d_early[ch];
        for (int r = 0; r <= s; r++) seq.push_back(ch);
        n++;
      end
    end
    lat = n * (s + 1);
    mask = m;
    data_in = d_early;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      if (n == 0) esel = last_sel[w];
      else if (k < lat) esel = 2'(seq[k]);
      else esel = 2'(seq[lat - 1]);
      chk("sel", 8'(o_sel), 8'(esel));
      chk("busy", 8'(o_busy), 8'(n > 0 && k < lat));
      chk("frame_valid", 8'(o_fv), 8'(k == lat));
      chk("frame", 8'(o_frame), 8'((k == lat) ? exp_frame : last_frame[w]));
      if (k == sw) data_in = d_late;
      if (disturb && k == 1) begin start = 1'b1; mask = 4'b0001; end
      if (disturb && k == 2) begin start = 1'b0; mask = m; end
    end
    last_sel[w] = esel;
    last_frame[w] = exp_frame;
    if (!chain) begin
      @(negedge clk);
      chk("post_fv", 8'(o_fv), 8'd0);
      chk("post_busy", 8'(o_busy), 8'd0);
      chk("post_sel", 8'(o_sel), 8'(esel));
      chk("post_frame", 8'(o_frame), 8'(exp_frame));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; which = 1'b0; mask = 4'd0; data_in = 4'd0;
    last_sel[0] = 2'd0; last_sel[1] = 2'd0;
    last_frame[0] = 4'd0; last_frame[1] = 4'd0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      which = w[0];
      #1;
      chk("rst_sel", 8'(o_sel), 8'd0);
      chk("rst_busy", 8'(o_busy), 8'd0);
      chk("rst_frame", 8'(o_frame), 8'd0);
      chk("rst_fv", 8'(o_fv), 8'd0);
    end
    which = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    scan(1'b0, 4'b1111, 4'b1010, 4'b1010, 0, 1'b0, 1'b0);  // full scan
    scan(1'b0, 4'b0101, 4'b1111, 4'b1111, 0, 1'b0, 1'b0);  // sparse
    scan(1'b0, 4'b0000, 4'b1111, 4'b1111, 0, 1'b0, 1'b0);  // empty mask
    scan(1'b1, 4'b0001, 4'b0000, 4'b0001, 3, 1'b0, 1'b0);  // settle sampling
    scan(1'b1, 4'b1011, 4'b0000, 4'b1111, 5, 1'b0, 1'b0);
    scan(1'b0, 4'b1111, 4'b0110, 4'b0110, 0, 1'b1, 1'b0);  // start/mask while busy
    scan(1'b0, 4'b0011, 4'b1111, 4'b1111, 0, 1'b0, 1'b1);  // back-to-back
    scan(1'b0, 4'b1100, 4'b0101, 4'b0101, 0, 1'b0, 1'b0);

    // Reset in cycle 3 of a full scan.
    which = 1'b0; mask = 4'b1111; data_in = 4'b1010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_sel", 8'(o_sel), 8'd0);
    chk("mid_rst_busy", 8'(o_busy), 8'd0);
    chk("mid_rst_frame", 8'(o_frame), 8'd0);
    chk("mid_rst_fv", 8'(o_fv), 8'd0);
    last_sel[0] = 2'd0; last_sel[1] = 2'd0;
    last_frame[0] = 4'd0; last_frame[1] = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_rst_no_fv", 8'(o_fv), 8'd0);
      chk("mid_rst_idle", 8'(o_busy), 8'd0);
    end
    scan(1'b0, 4'b1111, 4'b1001, 4'b1001, 0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      scan(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
           int'($urandom_range(0, 16)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
